nios_rddata_in: RTL

NIOS_RDDATA_IN -- requirements
Module: nios_rddata_in

---
 rtl/nios_pio_pkg.sv | 23 ++
 rtl/nios_sync_chain.sv | 25 ++
 rtl/nios_rddata_in.sv | 81 ++++++++
 3 files changed

// File: rtl/nios_pio_pkg.sv
// rtl/nios_pio_pkg.sv - shared PIO register offsets, edge-type encodings and edge helper
package nios_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

  function automatic logic [31:0] edge_vec(input logic [31:0] cur,
                                           input logic [31:0] prev,
                                           input int          kind);
    case (kind)
      EDGE_FALLING: edge_vec = ~cur & prev;
      EDGE_ANY:     edge_vec = cur ^ prev;
      default:      edge_vec = cur & ~prev;
    endcase
  endfunction

endpackage

// File: rtl/nios_sync_chain.sv
// rtl/nios_sync_chain.sv - multi-stage synchronizer for the asynchronous PIO input
module nios_sync_chain #(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] sync_val
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage_q, stage_d;

  always_comb begin
    stage_d = {stage_q[SYNC_STAGES-2:0], in_port};
  end

  always_ff @(posedge clk) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign sync_val = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/nios_rddata_in.sv
// rtl/nios_rddata_in.sv - Avalon-MM PIO input port with edge capture and masked interrupt
module nios_rddata_in
  import nios_pio_pkg::*;
#(
  parameter int WIDTH       = 12,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [2:0] WARM_MAX = 3'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_val;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [2:0]       warm_q, warm_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] edge_v, clr;
  logic             write_en, warm_done;
  logic             unused_wd;

  nios_sync_chain #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset   (reset),
    .in_port (in_port),
    .sync_val(sync_val)
  );

  assign unused_wd = ^writedata;

  always_comb begin
    write_en  = chipselect & ~write_n;
    warm_done = (warm_q == WARM_MAX);
    prev_d    = sync_val;
    warm_d    = warm_done ? warm_q : warm_q + 3'd1;
    // Edges are suppressed until the chain and prev hold real post-reset samples
    edge_v    = warm_done ? WIDTH'(edge_vec(32'(sync_val), 32'(prev_q), EDGE_TYPE)) : '0;
    mask_d    = (write_en && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
    clr       = (write_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
    edge_capture_d = (edge_capture_q & ~clr) | edge_v;
    case (address)
      ADDR_DATA: readdata_d = 32'(sync_val);
      ADDR_MASK: readdata_d = 32'(mask_q);
      ADDR_EDGE: readdata_d = 32'(edge_capture_q);
      default:   readdata_d = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q         <= '0;
      warm_q         <= '0;
      mask_q         <= '0;
      edge_capture_q <= '0;
      readdata_q     <= '0;
    end else begin
      prev_q         <= prev_d;
      warm_q         <= warm_d;
      mask_q         <= mask_d;
      edge_capture_q <= edge_capture_d;
      readdata_q     <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edge_capture_q & mask_q);

endmodule
